ota_stream_decimator: RTL

Digital back end for the OTA comparator. Takes the 1-bit asynchronous comparator output, synchronizes and deglitches it, and counts ones over a programmable window of 16 to 128 samples. It presents the density as an 8-bit code with a valid/ack handshake to the register/readout logic on the user outputs.

---
 rtl/ota_stream_decimator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ota_stream_decimator.sv
// OTA comparator back end: synchronizes and deglitches the comparator bit, counts
// ones over a 16..128 sample window and hands out a scaled 8-bit density.
module ota_stream_decimator #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bit_in,
    input  logic [1:0] osr_sel,
    input  logic       data_ack,
    input  logic       clr_ovr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       overrun,
    output logic       bit_filt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             hist_q;
    logic                   bit_filt_q;
    logic [6:0]             samp_cnt_q, samp_cnt_d;
    logic [7:0]             ones_q, ones_d;
    logic [1:0]             n_cur_q, n_cur_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   overrun_q, overrun_d;

    logic        s0, s1, s2, maj;
    logic        win_start, done;
    logic [1:0]  n_eff;
    logic [6:0]  last_cnt;
    logic [7:0]  total;
    logic [10:0] scaled;
    logic [7:0]  result;

    assign s0  = sync_q[SYNC_STAGES-1];
    assign s1  = hist_q[0];
    assign s2  = hist_q[1];
    assign maj = (s0 & s1) | (s0 & s2) | (s1 & s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            hist_q     <= '0;
            bit_filt_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bit_in};
            hist_q     <= {hist_q[0], s0};
            bit_filt_q <= maj;
        end
    end

    // The first RUN cycle always opens a window, so osr_sel is used directly there.
    always_comb begin
        win_start = (state_q == IDLE) || (samp_cnt_q == '0);
        n_eff     = win_start ? osr_sel : n_cur_q;
        case (n_eff)
            2'd0:    last_cnt = 7'd15;
            2'd1:    last_cnt = 7'd31;
            2'd2:    last_cnt = 7'd63;
            default: last_cnt = 7'd127;
        endcase
        done   = ena && (samp_cnt_q == last_cnt);
        total  = ones_q + {7'd0, bit_filt_q};
        scaled = {3'b000, total} << (2'd3 - n_eff);
        result = (scaled > 11'd255) ? 8'hFF : scaled[7:0];
    end

    always_comb begin
        state_d      = ena ? RUN : IDLE;
        samp_cnt_d   = samp_cnt_q;
        ones_d       = ones_q;
        n_cur_d      = n_cur_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        if (!ena) begin
            samp_cnt_d = '0;
            ones_d     = '0;
        end else begin
            if (win_start) n_cur_d = osr_sel;
            if (done) begin
                samp_cnt_d = '0;
                ones_d     = '0;
            end else begin
                samp_cnt_d = samp_cnt_q + 7'd1;
                ones_d     = ones_q + {7'd0, bit_filt_q};
            end
        end

        // Clear first so a same-edge overrun set takes priority.
        if (clr_ovr) overrun_d = 1'b0;
        if (done) begin
            data_out_d   = result;
            data_valid_d = 1'b1;
            if (data_valid_q && !data_ack) overrun_d = 1'b1;
        end else if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            samp_cnt_q   <= '0;
            ones_q       <= '0;
            n_cur_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            ones_q       <= ones_d;
            n_cur_q      <= n_cur_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign bit_filt   = bit_filt_q;

endmodule
